// File: rtl/debug_trace_mux.sv
// Probe-channel display mux with a triggered trace ring and trigger snapshot.
// Latency: disdata registered, 1 cycle from inputs/state; no backpressure, the ring samples every armed cycle.
module debug_trace_mux #(
   parameter int WIDTH = 32,
   parameter int NCH   = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NCH*WIDTH-1:0]       ch_data,
   input  logic [$clog2(NCH)-1:0]     ch_sel,
   input  logic [1:0]                 mode,
   input  logic                       arm,
   input  logic                       disarm,
   input  logic [WIDTH-1:0]           trig_val,
   input  logic [WIDTH-1:0]           trig_mask,
   input  logic [$clog2(DEPTH)-1:0]   post_cnt,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [WIDTH-1:0]           disdata,
   output logic [1:0]                 state,
   output logic                       trig_hit,
   output logic [$clog2(DEPTH):0]     fill
);
   localparam int SELW = $clog2(NCH);
   localparam int AW   = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} fsmState_t;

   fsmState_t        stReg;
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    remaining;
   logic [AW-1:0]    postLat;
   logic [SELW-1:0]  traceCh;
   logic [WIDTH-1:0] chArr [NCH];
   logic [WIDTH-1:0] snap  [NCH];
   logic [WIDTH-1:0] ring  [DEPTH];
   logic [WIDTH-1:0] dispNext;
   logic [AW-1:0]    rdAddr;
   logic             capEn;
   logic             match;
   logic             selOk;
   logic             rdOk;

   always_comb begin
      for (int k = 0; k < NCH; k++) chArr[k] = ch_data[k*WIDTH +: WIDTH];
   end

   assign state  = stReg;
   assign selOk  = (32'(ch_sel) < NCH);
   assign rdOk   = ({1'b0, rd_idx} < fill);
   // With fill saturated its low bits are zero, so this lands on the oldest surviving entry.
   assign rdAddr = wrPtr - fill[AW-1:0] + rd_idx;
   assign match  = ((chArr[0] ^ trig_val) & trig_mask) == '0;
   assign capEn  = !arm && !disarm && (stReg == ARMED || stReg == POST);

   always_ff @(posedge clk) begin
      if (capEn) ring[wrPtr] <= chArr[traceCh];
   end

   always_comb begin
      dispNext = '0;
      case (mode)
         2'b00:   if (selOk) dispNext = chArr[ch_sel];
         2'b01:   if (stReg == DONE && rdOk) dispNext = ring[rdAddr];
         2'b10:   if (selOk) dispNext = snap[ch_sel];
         default: dispNext = WIDTH'({stReg, trig_hit, fill});
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stReg     <= IDLE;
         disdata   <= '0;
         trig_hit  <= 1'b0;
         fill      <= '0;
         wrPtr     <= '0;
         remaining <= '0;
         postLat   <= '0;
         traceCh   <= '0;
         for (int k = 0; k < NCH; k++) snap[k] <= '0;
      end else begin
         disdata <= dispNext;
         if (arm) begin
            stReg    <= ARMED;
            wrPtr    <= '0;
            fill     <= '0;
            trig_hit <= 1'b0;
            traceCh  <= selOk ? ch_sel : '0;
            postLat  <= post_cnt;
         end else if (disarm && (stReg == ARMED || stReg == POST)) begin
            stReg <= DONE;
         end else if (capEn) begin
            wrPtr <= wrPtr + 1'b1;
            if (fill != (AW+1)'(DEPTH)) fill <= fill + 1'b1;
            if (stReg == ARMED) begin
               if (match) begin
                  trig_hit  <= 1'b1;
                  remaining <= postLat;
                  for (int k = 0; k < NCH; k++) snap[k] <= chArr[k];
                  stReg     <= (postLat == '0) ? DONE : POST;
               end
            end else begin
               remaining <= remaining - 1'b1;
               if (remaining == AW'(1)) stReg <= DONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_debug_trace_mux.sv
// Randomized and directed bench for debug_trace_mux against a queue-based reference model.
module tb_debug_trace_mux;
   localparam int W = 32;
   localparam int N = 8;
   localparam int D = 16;
   localparam int AW = 4;

   logic           clk;
   logic           reset;
   logic [N*W-1:0] ch_data;
   logic [2:0]     ch_sel;
   logic [1:0]     mode;
   logic           arm;
   logic           disarm;
   logic [W-1:0]   trig_val;
   logic [W-1:0]   trig_mask;
   logic [AW-1:0]  post_cnt;
   logic [AW-1:0]  rd_idx;
   logic [W-1:0]   disdata;
   logic [1:0]     state;
   logic           trig_hit;
   logic [AW:0]    fill;

   logic [W-1:0] ch [N];

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: held samples as a queue, oldest at the front.
   int           mState;
   bit           mHit;
   logic [W-1:0] mQ[$];
   logic [W-1:0] mSnap [N];
   int           mRem;
   int           mPost;
   int           mCh;
   logic [W-1:0] saved [N];

   debug_trace_mux #(.WIDTH(W), .NCH(N), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .ch_data(ch_data), .ch_sel(ch_sel), .mode(mode),
      .arm(arm), .disarm(disarm), .trig_val(trig_val), .trig_mask(trig_mask),
      .post_cnt(post_cnt), .rd_idx(rd_idx), .disdata(disdata), .state(state),
      .trig_hit(trig_hit), .fill(fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) ch_data[k*W +: W] = ch[k];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mState = 0; mHit = 0; mQ.delete(); mRem = 0; mPost = 0; mCh = 0;
      for (int k = 0; k < N; k++) mSnap[k] = '0;
   endtask

   task automatic step();
      logic [W-1:0] e;
      e = '0;
      case (mode)
         2'd0: e = ch[ch_sel];
         2'd1: if (mState == 3 && int'(rd_idx) < mQ.size()) e = mQ[rd_idx];
         2'd2: e = mSnap[ch_sel];
         default: e = W'(mState * 64 + int'(mHit) * 32 + mQ.size());
      endcase
      if (arm) begin
         mState = 1; mHit = 0; mQ.delete(); mCh = ch_sel; mPost = post_cnt;
      end else if (disarm && (mState == 1 || mState == 2)) begin
         mState = 3;
      end else if (mState == 1 || mState == 2) begin
         mQ.push_back(ch[mCh]);
         if (mQ.size() > D) void'(mQ.pop_front());
         if (mState == 1) begin
            if (((ch[0] ^ trig_val) & trig_mask) == '0) begin
               mHit = 1;
               for (int k = 0; k < N; k++) mSnap[k] = ch[k];
               mRem = mPost;
               mState = (mPost == 0) ? 3 : 2;
            end
         end else begin
            mRem--;
            if (mRem == 0) mState = 3;
         end
      end
      @(posedge clk); #1;
      check("state", 64'(state), 64'(mState));
      check("trig_hit", 64'(trig_hit), 64'(mHit));
      check("fill", 64'(fill), 64'(mQ.size()));
      check("disdata", 64'(disdata), 64'(e));
   endtask

   task automatic randCh();
      for (int k = 0; k < N; k++) ch[k] = $urandom;
   endtask

   initial begin
      reset = 1'b0; ch_sel = '0; mode = '0; arm = 0; disarm = 0;
      trig_val = '0; trig_mask = '0; post_cnt = '0; rd_idx = '0;
      for (int k = 0; k < N; k++) ch[k] = '0;
      modelReset();
      #12;
      check("rst_state", 64'(state), 64'd0);
      check("rst_disdata", 64'(disdata), 64'd0);
      check("rst_fill", 64'(fill), 64'd0);
      check("rst_hit", 64'(trig_hit), 64'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // Live mux
      randCh(); ch[3] = 32'hDEAD_BEEF; ch_sel = 3'd3; mode = 2'd0;
      step();
      check("live_ch3", 64'(disdata), 64'hDEAD_BEEF);
      ch[1] = 32'h1234_5678; ch_sel = 3'd1;
      step();
      check("live_ch1", 64'(disdata), 64'h1234_5678);

      // PC breakpoint with 3 post samples
      ch_sel = 3'd0; trig_val = 32'h0040_0020; trig_mask = 32'hFFFF_FFFF; post_cnt = 4'd3;
      arm = 1; step(); arm = 0;
      for (int i = 0; i < 12; i++) begin
         randCh(); ch[0] = 32'h0040_0000 + 32'(4 * i);
         step();
         if (i == 8) check("bp_hit_at9", 64'(trig_hit), 64'd1);
      end
      check("bp_done", 64'(state), 64'd3);
      check("bp_fill", 64'(fill), 64'd12);
      mode = 2'd1;
      for (int i = 0; i < 12; i++) begin
         rd_idx = 4'(i); step();
         check("bp_rb", 64'(disdata), 64'(32'h0040_0000 + 32'(4 * i)));
      end

      // Wrapping ring: trigger on 30th capture, post 2
      mode = 2'd0; ch_sel = 3'd0; trig_val = 32'd1029; post_cnt = 4'd2;
      arm = 1; step(); arm = 0;
      for (int i = 0; i < 32; i++) begin
         randCh(); ch[0] = 32'(1000 + i); step();
      end
      check("wrap_fill", 64'(fill), 64'd16);
      mode = 2'd1; rd_idx = 4'd0; step();
      check("wrap_rb0", 64'(disdata), 64'd1016);
      rd_idx = 4'd15; step();
      check("wrap_rb15", 64'(disdata), 64'd1031);

      // Mask 0, post 0: immediate trigger and snapshot
      mode = 2'd0; trig_mask = '0; post_cnt = 4'd0; ch_sel = 3'd5;
      arm = 1; step(); arm = 0;
      randCh();
      for (int k = 0; k < N; k++) saved[k] = ch[k];
      step();
      check("m0_done", 64'(state), 64'd3);
      check("m0_fill", 64'(fill), 64'd1);
      mode = 2'd2; randCh();
      for (int k = 0; k < N; k++) begin
         ch_sel = 3'(k); step();
         check("snap", 64'(disdata), 64'(saved[k]));
      end

      // Disarm without match, then arm+disarm together
      mode = 2'd3; trig_val = 32'hFFFF_FFFF; trig_mask = 32'hFFFF_FFFF; ch_sel = 3'd2;
      arm = 1; step(); arm = 0;
      for (int i = 0; i < 5; i++) begin
         randCh(); ch[0] = ch[0] & 32'h7FFF_FFFF; step();
      end
      disarm = 1; step(); disarm = 0;
      check("dis_state", 64'(state), 64'd3);
      check("dis_hit", 64'(trig_hit), 64'd0);
      check("dis_fill", 64'(fill), 64'd5);
      arm = 1; disarm = 1; step(); arm = 0; disarm = 0;
      check("armdis_state", 64'(state), 64'd1);
      check("armdis_fill", 64'(fill), 64'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         arm = ($urandom_range(0, 40) == 0);
         disarm = ($urandom_range(0, 60) == 0);
         if (arm) begin
            post_cnt = 4'($urandom);
            trig_val = 32'($urandom_range(0, 15));
            trig_mask = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'hFFFF_FFFF;
         end
         mode = 2'($urandom); ch_sel = 3'($urandom); rd_idx = 4'($urandom);
         randCh(); ch[0] = 32'($urandom_range(0, 63));
         step();
      end
      arm = 0; disarm = 0;

      // Reset asserted in the middle of POST
      trig_mask = '0; post_cnt = 4'd15; mode = 2'd2; ch_sel = 3'd4;
      arm = 1; step(); arm = 0;
      randCh(); step(); step(); step();
      check("pre_rst_post", 64'(state), 64'd2);
      #3 reset = 1'b0;
      #1;
      modelReset();
      check("mid_rst_state", 64'(state), 64'd0);
      check("mid_rst_disdata", 64'(disdata), 64'd0);
      check("mid_rst_fill", 64'(fill), 64'd0);
      check("mid_rst_hit", 64'(trig_hit), 64'd0);
      @(negedge clk); reset = 1'b1;
      mode = 2'd1; rd_idx = 4'd0;
      step();
      check("rst_rb", 64'(disdata), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
